// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Holds the FSM state encoding and the port index constants.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the port not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |valid;
        grant = PORT_I;
        if (valid[0] && valid[1]) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-refill port and a data port onto one single-beat memory bus.
// Latency: read done 3 cycles after the granting edge's cycle, write done 2, plus any mem_ready stall.
// Backpressure: mem_ready=0 freezes the FSM and all mem_* outputs indefinitely.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    input  logic                req0_we,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [WIDTH-1:0]    req0_wdata,
    output logic                req0_done,
    output logic [2*WIDTH-1:0]  req0_rdata,

    input  logic                req1_valid,
    input  logic                req1_we,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [WIDTH-1:0]    req1_wdata,
    output logic                req1_done,
    output logic [2*WIDTH-1:0]  req1_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    input  logic                mem_ready,

    output logic                busy
);

    arb_state_t         state, state_nxt;
    logic               last_grant;
    logic               gnt;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [WIDTH-1:0]   lat_wdata;
    logic [WIDTH-1:0]   word_lo, word_hi;

    logic               pick;
    logic               any_vld;
    logic               beat_ok;
    logic [ADDR_W-1:0]  line_base;

    rr_pick2 u_pick (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (pick),
        .any        (any_vld)
    );

    assign beat_ok   = mem_en && mem_ready;
    assign line_base = {lat_addr[ADDR_W-1:3], 3'b000};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= PORT_D;
            gnt        <= PORT_I;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            word_lo    <= '0;
            word_hi    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_vld) begin
                gnt        <= pick;
                last_grant <= pick;
                lat_we     <= pick ? req1_we    : req0_we;
                lat_addr   <= pick ? req1_addr  : req0_addr;
                lat_wdata  <= pick ? req1_wdata : req0_wdata;
                // Writes return zero line data, so stale words must not survive a new grant.
                word_lo    <= '0;
                word_hi    <= '0;
            end
            if (state == BEAT0 && beat_ok && !lat_we) begin
                word_lo <= mem_rdata;
            end
            if (state == BEAT1 && beat_ok) begin
                word_hi <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        req0_rdata = '0;
        req1_rdata = '0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (any_vld) state_nxt = BEAT0;
            end
            BEAT0: begin
                mem_en = 1'b1;
                if (lat_we) begin
                    mem_we    = 1'b1;
                    mem_addr  = lat_addr;
                    mem_wdata = lat_wdata;
                    if (mem_ready) state_nxt = DONE;
                end else begin
                    mem_addr = line_base;
                    if (mem_ready) state_nxt = BEAT1;
                end
            end
            BEAT1: begin
                mem_en   = 1'b1;
                mem_addr = {lat_addr[ADDR_W-1:3], 3'b100};
                if (mem_ready) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                if (gnt == PORT_I) begin
                    req0_done  = 1'b1;
                    req0_rdata = {word_hi, word_lo};
                end else begin
                    req1_done  = 1'b1;
                    req1_rdata = {word_hi, word_lo};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected beats and completions are queued at issue time
// and checked by a negedge monitor as the DUT produces them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req0_done;
    logic [63:0] req0_rdata;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req1_done;
    logic [63:0] req1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready = 1'b1;
    logic        busy;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct { logic port; logic [63:0] rdata; } done_t;

    beat_t sb_beat[$];
    done_t sb_done[$];
    beat_t mon_b;
    done_t mon_d;
    logic  model_last = 1'b1;
    int    n_vec = 0;
    int    n_bad = 0;

    mem_arbiter #(.WIDTH(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h0001_0000) return 32'h0000_0011;
        if (a == 32'h0001_0004) return 32'h0000_0022;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    assign mem_rdata = data_for(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en && mem_ready) begin
            if (sb_beat.size() == 0) begin
                chk("unexpected_beat", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_b = sb_beat.pop_front();
                chk("beat_addr", {32'd0, mem_addr}, {32'd0, mon_b.addr});
                chk("beat_we", {63'd0, mem_we}, {63'd0, mon_b.we});
                if (mon_b.we) chk("beat_wdata", {32'd0, mem_wdata}, {32'd0, mon_b.wdata});
            end
        end
        if (req0_done || req1_done) begin
            chk("done_exclusive", {63'd0, req0_done & req1_done}, 64'd0);
            if (sb_done.size() == 0) begin
                chk("unexpected_done", {62'd0, req1_done, req0_done}, 64'd0);
            end else begin
                mon_d = sb_done.pop_front();
                chk("done_port", {63'd0, req1_done}, {63'd0, mon_d.port});
                chk("done_rdata", req1_done ? req1_rdata : req0_rdata, mon_d.rdata);
            end
        end
    end

    task automatic push_expect(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wd);
        logic [31:0] al;
        al = {addr[31:3], 3'b000};
        if (we) begin
            sb_beat.push_back('{1'b1, addr, wd});
            sb_done.push_back('{port, 64'd0});
        end else begin
            sb_beat.push_back('{1'b0, al, 32'd0});
            sb_beat.push_back('{1'b0, al + 32'd4, 32'd0});
            sb_done.push_back('{port, {data_for(al + 32'd4), data_for(al)}});
        end
        model_last = port;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        mem_ready  = 1'b1;
        sb_beat.delete();
        sb_done.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy",   {63'd0, busy},      64'd0);
        chk("rst_mem_en", {63'd0, mem_en},    64'd0);
        chk("rst_mem_we", {63'd0, mem_we},    64'd0);
        chk("rst_addr",   {32'd0, mem_addr},  64'd0);
        chk("rst_wdata",  {32'd0, mem_wdata}, 64'd0);
        chk("rst_done0",  {63'd0, req0_done}, 64'd0);
        chk("rst_done1",  {63'd0, req1_done}, 64'd0);
        chk("rst_rdata0", req0_rdata,         64'd0);
        chk("rst_rdata1", req1_rdata,         64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit rnd, input int exp_lat);
        int cyc;
        bit seen;
        push_expect(port, we, addr, wd);
        if (port) begin
            req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (port ? req1_done : req0_done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (rnd) begin
                    mem_ready = ($urandom_range(0, 3) != 0);
                    if (port) begin
                        req0_we = 1'($urandom_range(0, 1)); req0_addr = $urandom; req0_wdata = $urandom;
                    end else begin
                        req1_we = 1'($urandom_range(0, 1)); req1_addr = $urandom; req1_wdata = $urandom;
                    end
                end
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        else if (exp_lat >= 0) chk("done_latency", 64'(cyc), 64'(exp_lat));
        @(posedge clk); #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic tie_reads(input logic [31:0] a0, input logic [31:0] a1, input logic exp_first);
        logic win;
        bit   s0, s1;
        logic first;
        int   cyc;
        win = ~model_last;
        push_expect(win,  1'b0, win ? a1 : a0, 32'd0);
        push_expect(~win, 1'b0, win ? a0 : a1, 32'd0);
        req0_we = 1'b0; req0_addr = a0; req0_valid = 1'b1;
        req1_we = 1'b0; req1_addr = a1; req1_valid = 1'b1;
        s0 = 1'b0; s1 = 1'b0; first = 1'b0; cyc = 0;
        while (!(s0 && s1) && cyc < 300) begin
            @(negedge clk);
            if (req0_done && !s0) begin s0 = 1'b1; if (!s1) first = 1'b0; end
            if (req1_done && !s1) begin s1 = 1'b1; if (!s0) first = 1'b1; end
            @(posedge clk); #1;
            if (s0) req0_valid = 1'b0;
            if (s1) req1_valid = 1'b0;
            cyc++;
        end
        if (!(s0 && s1)) chk("tie_timeout", 64'd0, 64'd1);
        else chk("tie_first", {63'd0, first}, {63'd0, exp_first});
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();

        // Ties after reset: port 0 first, and again only once port 1 has had its turn.
        tie_reads(32'h0004_0000, 32'h0004_0100, 1'b0);
        tie_reads(32'h0004_0200, 32'h0004_0300, 1'b0);
        do_req(1'b0, 1'b0, 32'h0004_0400, 32'd0, 1'b0, 3);
        tie_reads(32'h0004_0500, 32'h0004_0600, 1'b1);

        do_req(1'b1, 1'b0, 32'h0001_0004, 32'd0,         1'b0, 3);
        do_req(1'b0, 1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 1'b0, 2);

        // Stall in BEAT1.
        push_expect(1'b0, 1'b0, 32'h0002_0000, 32'd0);
        req0_we = 1'b0; req0_addr = 32'h0002_0000; req0_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_addr", {32'd0, mem_addr}, 64'h0000_0000_0002_0004);
            chk("stall_en", {63'd0, mem_en}, 64'd1);
            chk("stall_no_done", {63'd0, req0_done}, 64'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_no_done_yet", {63'd0, req0_done}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_done", {63'd0, req0_done}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while BEAT1 is stalled: abort with no completion.
        push_expect(1'b1, 1'b0, 32'h0003_0008, 32'd0);
        req1_we = 1'b0; req1_addr = 32'h0003_0008; req1_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst = 1'b0;
        sb_beat.delete();
        sb_done.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        req1_valid = 1'b0;
        mem_ready = 1'b1;
        model_last = 1'b1;
        @(negedge clk);
        chk("abort_mem_en", {63'd0, mem_en},    64'd0);
        chk("abort_busy",   {63'd0, busy},      64'd0);
        chk("abort_done",   {63'd0, req1_done}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'h0003_0008, 32'd0, 1'b0, 3);

        // Random single-port traffic with stalls and noise on the idle port.
        for (int i = 0; i < 12; i++) begin
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, 1'b1, -1);
        end

        repeat (3) @(posedge clk);
        chk("sb_beat_drained", 64'(sb_beat.size()), 64'd0);
        chk("sb_done_drained", 64'(sb_done.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 reqN_valid  input  1  request from port N (N=0 instruction refill, N=1 data cache miss/write-through); held until reqN_done.
REQ-006 reqN_we  input  1  1 = single-word write, 0 = two-word line read; held with valid.
REQ-007 reqN_addr  input  ADDR_W  byte address; held with valid.
REQ-008 reqN_wdata  input  WIDTH  write data; held with valid.
REQ-009 reqN_done  output  1  one-cycle completion pulse to port N.
REQ-010 reqN_rdata  output  2*WIDTH  line data, {word at +4, word at +0}; valid while reqN_done=1.
REQ-011 mem_en, mem_we  output  1 each  memory access strobe and write qualifier.
REQ-012 mem_addr, mem_wdata  output  ADDR_W, WIDTH  memory beat address and write data.
REQ-013 mem_rdata  input  WIDTH  memory read data, sampled when mem_en & mem_ready.
REQ-014 mem_ready  input  1  memory beat-accept; a beat completes on any edge with mem_en=1 and mem_ready=1.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL use states IDLE, BEAT0, BEAT1 and DONE.
REQ-017 In IDLE with any valid, the block SHALL latch the winner and its we/addr/wdata, then enter BEAT0 on the next edge.
REQ-018 Arbitration SHALL be round-robin: a single requester wins; on a tie, the port not granted last wins; last_grant SHALL update on each grant.
REQ-019 In BEAT0 and BEAT1, mem_en SHALL be 1; in IDLE and DONE, mem_en SHALL be 0.
REQ-020 For a read, BEAT0 SHALL drive mem_addr = {addr[ADDR_W-1:3],3'b000} with mem_we=0, capture the low word on beat completion, and enter BEAT1.
REQ-021 BEAT1 SHALL drive mem_addr = that aligned address + 4, capture the high word on beat completion, and enter DONE.
REQ-022 For a write, BEAT0 SHALL drive the unmodified addr with mem_we=1 and mem_wdata=wdata, then enter DONE on completion; BEAT1 SHALL be skipped.
REQ-023 While mem_ready=0, the FSM SHALL hold its state with all mem_* outputs stable; wait time SHALL be unbounded.
REQ-024 DONE SHALL last exactly one cycle, assert only the granted port's done with rdata from the captured words (0 for writes), then return to IDLE.
REQ-025 With mem_ready held at 1, read done SHALL assert 3 cycles after the edge sampling valid, and write done 2 cycles after.
REQ-026 A requester SHALL NOT be re-granted in the cycle of its done; the earliest new grant is the IDLE cycle that follows.
REQ-027 Changes to a non-granted port's inputs SHALL have no effect on the transaction in flight.

Reset
REQ-028 On a clock edge with rst=0, the block SHALL enter IDLE and clear the latched request and captured words.
REQ-029 Reset SHALL set last_grant=1, so port 0 wins the first tie.
REQ-030 Reset SHALL force all outputs to 0 (done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy).
REQ-031 Reset mid-transaction SHALL abort without issuing done; mem_en SHALL be 0 from the following cycle.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, BEAT0, BEAT1, DONE) and constants PORT_I=0 and PORT_D=1.
REQ-033 Sub-module rr_pick2 SHALL implement the combinational two-input round-robin choice (valids, last_grant -> grant index, any).
REQ-034 The rest SHALL live in mem_arbiter: FSM, request latch and word capture registers.

Verification
REQ-035 Port 1 read at 0x00010004, mem_ready=1 with mem_rdata=0x11 then 0x22 -> addrs 0x00010000 then 0x00010004; req1_done 3 cycles after valid; req1_rdata=0x00000022_00000011.
REQ-036 Port 0 write addr 0x00010008, wdata 0xDEADBEEF -> one beat with mem_we=1 at 0x00010008; req0_done after 2 cycles; rdata=0.
REQ-037 Both ports read simultaneously after reset -> port 0 served first, then port 1; a repeated tie serves port 0 again only after port 1 has been served.
REQ-038 mem_ready held at 0 for 5 cycles in BEAT1 -> mem_addr stays at base+4, no done; done follows 1 cycle after mem_ready rises.
REQ-039 rst=0 asserted in BEAT1 -> next cycle IDLE, mem_en=0, busy=0, no done pulse; a fresh request then completes normally.
